uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Serial transmit stage downstream of the Microcontroller; drives the currently unused o_TXD1 board pin.
- Accepts bytes (register values, PC, etc.) on a valid/ready write port.
- Buffers the bytes in a small synchronous FIFO and transmits each one as an 8N1 UART frame, LSB first.
- Runs on the same 5 MHz system clock used by the LED, DIP and seven-segment drivers.

Parameters:
- CLKS_PER_BIT, 521, clock cycles per UART bit (9600 baud at 5 MHz); legal range 2..65535.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (default 8).

Ports:
- i_CLK  in  1  system clock; all logic on rising edge.
- i_RST  in  1  asynchronous, active-low reset.
- i_Data  in  8  byte to enqueue.
- i_Valid  in  1  write request; sampled on the rising edge.
- o_Ready  out  1  FIFO not full; combinational from the registered count.
- i_ClrOvf  in  1  synchronous clear of o_Overflow.
- o_TXD  out  1  serial line; registered; idle high.
- o_Busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- o_Count  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW; excludes the byte currently in the shifter.
- o_Overflow  out  1  sticky flag: a write was attempted while the FIFO was full.

Behaviour:
- Reset (i_RST=0, asynchronous):
  - Outputs: o_TXD=1, o_Count=0, o_Overflow=0, o_Busy=0, o_Ready=1.
  - Internal: FSM=IDLE; read/write pointers, baud counter and bit counter all 0.
  - Reset mid-frame: the line returns high immediately and all pending bytes are discarded.
- Write handshake:
  - A byte is accepted at an edge where i_Valid=1 and o_Ready=1. It is written at wptr, and wptr increments modulo depth.
  - i_Valid=1 while o_Ready=0: the byte is dropped, the FIFO is unchanged, and o_Overflow is set at that edge.
  - The full condition is evaluated before any pop. A pop in the same cycle does not make room.
- o_Overflow:
  - Cleared by i_ClrOvf=1 at an edge.
  - If an overflow and i_ClrOvf occur at the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state. A bit ends at the edge where the count equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - IDLE: o_TXD=1. At an edge with o_Count!=0:
    - load the shifter from FIFO[rptr]; increment rptr (pop); go to START.
  - START: o_TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_TXD=shifter[0] for CLKS_PER_BIT cycles per bit, LSB first.
    - The shifter shifts right at each bit end.
    - After bit index 7 ends, go to STOP.
  - STOP: o_TXD=1 for CLKS_PER_BIT cycles. At the end:
    - if the FIFO is non-empty, pop and go straight to START (no idle gap between frames);
    - otherwise go to IDLE.
- o_TXD is registered, so its value follows the state entered at each edge.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a byte accepted into an empty FIFO at edge k is popped at edge k+1. o_TXD falls after edge k+1.
- o_Count update per edge:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
  - Pointers wrap modulo depth; full is o_Count==depth.
- Bytes are transmitted in strict write order and are never duplicated or reordered.

Test Plan:
- Reset then idle (CLKS_PER_BIT=4, FIFO_AW=3 for all tests):
  - Stimulus: assert i_RST=0 mid-operation, release, run 50 cycles with no writes.
  - Required: o_TXD=1, o_Busy=0, o_Count=0, o_Ready=1, o_Overflow=0 throughout.
- Single byte:
  - Stimulus: write 0xA5 at edge k.
  - Required: o_TXD low from edge k+1 for 4 cycles; then bits 1,0,1,0,0,1,0,1 for 4 cycles each; then stop bit high for 4 cycles; o_Busy falls at the end (40 cycles total); the bench UART decoder reads 0xA5.
- Back-to-back:
  - Stimulus: write 0x01, 0x02, 0x03 on consecutive edges.
  - Required: o_Count peaks at 2; three contiguous frames (120 cycles) with no idle gap; decoded 0x01, 0x02, 0x03.
- Full/overflow:
  - Stimulus: write 10 bytes 0x10..0x19 on consecutive edges while the first frame is in flight.
  - Required: o_Ready drops when o_Count=8; 0x19 is dropped; o_Overflow=1; decoded stream is 0x10..0x18; i_ClrOvf=1 clears the flag.
- Reset mid-frame:
  - Stimulus: pulse i_RST low during DATA bit 3 with 4 bytes queued.
  - Required: o_TXD=1 immediately (asynchronous); o_Count=0; no further frames are sent.
- Wrap-around:
  - Stimulus: stream 20 random bytes, keeping the FIFO partly full (pointers wrap twice).
  - Required: the decoded sequence equals the written sequence exactly.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Byte write port (valid/ready) into the UART transmit FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic [7:0] i_Data;
    logic       i_Valid;
    logic       o_Ready;

    modport master (output i_Data, output i_Valid, input  o_Ready);
    modport slave  (input  i_Data, input  i_Valid, output o_Ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding an 8N1 UART transmitter, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 521,
    parameter int FIFO_AW      = 3
) (
    input  wire logic               i_CLK,
    input  wire logic               i_RST,
    uart_tx_fifo_if.slave           wr,
    input  wire logic               i_ClrOvf,
    output logic                    o_TXD,
    output logic                    o_Busy,
    output logic [FIFO_AW:0]        o_Count,
    output logic                    o_Overflow
);

    localparam int           c_DEPTH    = 2 ** FIFO_AW;
    localparam logic [15:0]  c_BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    state_t             r_state;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_txd;

    state_t             w_state_nxt;
    logic [15:0]        w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_txd_nxt;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_nonempty;
    logic               w_bit_end;

    // Occupancy never exceeds the depth, so the MSB alone marks full.
    assign w_full     = r_count[FIFO_AW];
    assign w_nonempty = (r_count != '0);
    assign w_push     = wr.i_Valid && !w_full;
    assign w_bit_end  = (r_baud == c_BAUD_MAX);

    assign wr.o_Ready = !w_full;
    assign o_TXD      = r_txd;
    assign o_Count    = r_count;
    assign o_Overflow = r_ovf;
    assign o_Busy     = (r_state != S_IDLE) || w_nonempty;

    always_ff @(posedge i_CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr.i_Data;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (FIFO_AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (FIFO_AW+1)'(1);
            end
            // A new overflow takes priority over a clear at the same edge.
            if (wr.i_Valid && w_full) begin
                r_ovf <= 1'b1;
            end else if (i_ClrOvf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = (r_state == S_IDLE || w_bit_end) ? '0 : r_baud + 16'd1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (w_bit_end) begin
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo with a serial-line decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int AW  = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          txd;
    logic          busy;
    logic          ovf;
    logic [AW:0]   count;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    sb[$];
    int unsigned   starts[$];
    int unsigned   cyc = 0;

    uart_tx_fifo_if u_if();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .i_CLK      (clk),
        .i_RST      (rst_n),
        .wr         (u_if),
        .i_ClrOvf   (clr_ovf),
        .o_TXD      (txd),
        .o_Busy     (busy),
        .o_Count    (count),
        .o_Overflow (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial decoder: first low sample at negedge n, bit i centred at n+4*(i+1)+2.
    task automatic decode_frame();
        logic [7:0] b = '0;
        logic [7:0] exp_b;
        logic       stop_v = 1'b0;
        starts.push_back(cyc);
        for (int s = 1; s <= 38; s++) begin
            @(negedge clk);
            if (!rst_n) return;
            if (s == 2) begin
                checks++;
                if (txd !== 1'b0) begin
                    errors++;
                    $display("FAIL start_bit: txd=%b required 0", txd);
                end
            end
            if (s >= 6 && s <= 34 && ((s - 6) % 4) == 0) b[(s - 6) / 4] = txd;
            if (s == 38) stop_v = txd;
        end
        checks++;
        if (stop_v !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit: txd=%b required 1", stop_v);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: decoded=%02h required none", b);
        end else begin
            exp_b = sb.pop_front();
            if (b !== exp_b) begin
                errors++;
                $display("FAIL frame_data: decoded=%02h required %02h", b, exp_b);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd === 1'b0) decode_frame();
        end
    end

    task automatic drive_byte(input logic [7:0] b, input bit exp_rdy);
        @(negedge clk);
        checks++;
        if (u_if.o_Ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready_at_write: o_Ready=%b required %b", u_if.o_Ready, exp_rdy);
        end
        u_if.i_Data  = b;
        u_if.i_Valid = 1'b1;
        if (exp_rdy) sb.push_back(b);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        u_if.i_Valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_%s: pending=%0d busy=%b required 0 0", name, sb.size(), busy);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({txd, busy, count, u_if.o_Ready, ovf} !== {1'b1, 1'b0, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s: txd=%b busy=%b count=%0d ready=%b ovf=%b required 1 0 0 1 0",
                     name, txd, busy, count, u_if.o_Ready, ovf);
        end
    endtask

    task automatic test_reset();
        drive_byte(8'h3C, 1'b1);
        idle_bus();
        repeat (10) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_txd: txd=%b required 0", txd);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL reset_async: txd=%b count=%0d required 1 0", txd, count);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_idle("reset_idle");
        end
    endtask

    task automatic test_single();
        logic [7:0] v = 8'hA5;
        logic       exp_t;
        drive_byte(v, 1'b1);
        idle_bus();
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j <= 4)       exp_t = 1'b0;
            else if (j <= 36) exp_t = v[(j - 5) / 4];
            else              exp_t = 1'b1;
            checks++;
            if (txd !== exp_t || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_bit%0d: txd=%b busy=%b required %b 1", j, txd, busy, exp_t);
            end
        end
        @(negedge clk);
        check_idle("single_end");
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        logic [AW:0] maxc;
        int          n = 0;
        starts.delete();
        drive_byte(8'h01, 1'b1);
        drive_byte(8'h02, 1'b1);
        drive_byte(8'h03, 1'b1);
        idle_bus();
        maxc = count;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (count > maxc) maxc = count;
        end
        checks++;
        if (n !== 119) begin
            errors++;
            $display("FAIL b2b_duration: cycles=%0d required 119", n);
        end
        checks++;
        if (maxc !== 4'd2) begin
            errors++;
            $display("FAIL b2b_peak_count: peak=%0d required 2", maxc);
        end
        wait_drain("b2b");
        checks++;
        if (starts.size() !== 3) begin
            errors++;
            $display("FAIL b2b_frames: frames=%0d required 3", starts.size());
        end else if (starts[1] - starts[0] !== 40 || starts[2] - starts[1] !== 40) begin
            errors++;
            $display("FAIL b2b_gap: spacing=%0d,%0d required 40,40",
                     starts[1] - starts[0], starts[2] - starts[1]);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) drive_byte(8'(8'h10 + i), i < 9);
        idle_bus();
        checks++;
        if (ovf !== 1'b1 || count !== 4'd8 || u_if.o_Ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b count=%0d ready=%b required 1 8 0", ovf, count, u_if.o_Ready);
        end
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b required 0", ovf);
        end
        wait_drain("overflow");
    endtask

    task automatic test_reset_midframe();
        bit seen_low = 1'b0;
        for (int i = 0; i < 5; i++) drive_byte(8'(8'h40 + i), 1'b1);
        idle_bus();
        repeat (14) @(negedge clk);
        checks++;
        if (count !== 4'd4 || txd !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: count=%0d txd=%b required 4 0", count, txd);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: txd=%b count=%0d busy=%b required 1 0 0", txd, count, busy);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) seen_low = 1'b1;
        end
        checks++;
        if (seen_low) begin
            errors++;
            $display("FAIL midrst_quiet: line went low=1 required 0");
        end
        check_idle("midrst_idle");
    endtask

    task automatic test_wrap();
        int n;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            n = 0;
            while (u_if.o_Ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL wrap_ready_timeout: ready=%b required 1", u_if.o_Ready);
            end
            drive_byte(8'($urandom_range(0, 255)), 1'b1);
            idle_bus();
        end
        wait_drain("wrap");
    endtask

    initial begin
        u_if.i_Data  = '0;
        u_if.i_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
